// File: rtl/csr_file.sv
// Machine-mode CSR file and trap-state holder for the single-cycle RV32I core.
// Reads are combinational and return the pre-update value; all state changes
// land on the rising clock edge with priority trap > mret > CSR write.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter int unsigned HART_ID     = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_csr_en,
    input  logic [1:0]  i_csr_op,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    input  logic        i_csr_src_zero,
    output logic [31:0] o_csr_rdata,
    output logic        o_csr_illegal,
    input  logic        i_trap_req,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_trap_tval,
    input  logic        i_mret,
    input  logic        i_retire,
    output logic [31:0] o_trap_vector,
    output logic [31:0] o_mepc,
    output logic        o_mie_global
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 64;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mie;
    logic [CW-1:0]   mcycle;
    logic [CW-1:0]   minstret;

    logic [XLEN-1:0] mstatus_rd;
    logic            mapped;
    logic            write_try;
    logic            wr_en;
    logic [XLEN-1:0] wval;
    logic [CW-1:0]   mcycle_nxt;
    logic [CW-1:0]   minstret_nxt;
    logic [XLEN-1:0] tvec_base;

    // mstatus view: MPP hard-wired to M-mode, only MIE/MPIE live
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

    // Address decode and read mux (old value of the addressed CSR)
    always_comb begin
        o_csr_rdata = '0;
        mapped      = 1'b1;
        case (i_csr_addr)
            12'h300:                         o_csr_rdata = mstatus_rd;
            12'h301:                         o_csr_rdata = MISA_VALUE;
            12'h304:                         o_csr_rdata = mie;
            12'h305:                         o_csr_rdata = mtvec;
            12'h340:                         o_csr_rdata = mscratch;
            12'h341:                         o_csr_rdata = mepc;
            12'h342:                         o_csr_rdata = mcause;
            12'h343:                         o_csr_rdata = mtval;
            12'h344:                         o_csr_rdata = '0;
            12'hB00, 12'hC00:                o_csr_rdata = mcycle[31:0];
            12'hB02, 12'hC02:                o_csr_rdata = minstret[31:0];
            12'hB80, 12'hC80:                o_csr_rdata = mcycle[63:32];
            12'hB82, 12'hC82:                o_csr_rdata = minstret[63:32];
            12'hF11, 12'hF12, 12'hF13:       o_csr_rdata = '0;
            12'hF14:                         o_csr_rdata = XLEN'(HART_ID);
            default:                         mapped      = 1'b0;
        endcase
    end

    // Access legality and the modified write value
    always_comb begin
        write_try     = (i_csr_op == OP_RW) ||
                        (((i_csr_op == OP_RS) || (i_csr_op == OP_RC)) && !i_csr_src_zero);
        o_csr_illegal = i_csr_en && (!mapped || (write_try && (i_csr_addr[11:10] == 2'b11)));
        wr_en         = i_csr_en && write_try && !o_csr_illegal && !i_trap_req;
        case (i_csr_op)
            OP_RW:   wval = i_csr_wdata;
            OP_RS:   wval = o_csr_rdata | i_csr_wdata;
            OP_RC:   wval = o_csr_rdata & ~i_csr_wdata;
            default: wval = o_csr_rdata;
        endcase
    end

    // Counter next values: a written half replaces, the other half still carries
    always_comb begin
        mcycle_nxt   = mcycle + CW'(1);
        minstret_nxt = minstret;
        if (i_retire && !i_trap_req)
            minstret_nxt = minstret + CW'(1);
        if (wr_en && (i_csr_addr == 12'hB00)) mcycle_nxt[31:0]    = wval;
        if (wr_en && (i_csr_addr == 12'hB80)) mcycle_nxt[63:32]   = wval;
        if (wr_en && (i_csr_addr == 12'hB02)) minstret_nxt[31:0]  = wval;
        if (wr_en && (i_csr_addr == 12'hB82)) minstret_nxt[63:32] = wval;
    end

    // Trap target: vectored mode offsets interrupts by 4*code
    always_comb begin
        tvec_base     = {mtvec[31:2], 2'b00};
        o_trap_vector = tvec_base;
        if (mtvec[0] && i_trap_cause[31])
            o_trap_vector = tvec_base + {i_trap_cause[29:0], 2'b00};
    end

    assign o_mepc       = mepc;
    assign o_mie_global = mstatus_mie;

    // CSR state: trap entry, then mret, then software writes
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec        <= MTVEC_RESET;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mscratch     <= '0;
            mie          <= '0;
            mcycle       <= '0;
            minstret     <= '0;
        end else begin
            mcycle   <= mcycle_nxt;
            minstret <= minstret_nxt;
            if (i_trap_req) begin
                mepc         <= {i_trap_pc[31:2], 2'b00};
                mcause       <= i_trap_cause;
                mtval        <= i_trap_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (i_mret) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end else if (wr_en && (i_csr_addr == 12'h300)) begin
                    mstatus_mie  <= wval[3];
                    mstatus_mpie <= wval[7];
                end
                if (wr_en) begin
                    case (i_csr_addr)
                        12'h304: mie      <= wval & MIE_MASK;
                        12'h305: mtvec    <= {wval[31:2], 1'b0, wval[0] & ~wval[1]};
                        12'h340: mscratch <= wval;
                        12'h341: mepc     <= {wval[31:2], 2'b00};
                        12'h342: mcause   <= wval;
                        12'h343: mtval    <= wval;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
module tb_csr_file;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    logic        i_clk;
    logic        i_rst;
    logic        i_csr_en;
    logic [1:0]  i_csr_op;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic        i_csr_src_zero;
    logic [31:0] o_csr_rdata;
    logic        o_csr_illegal;
    logic        i_trap_req;
    logic [31:0] i_trap_cause;
    logic [31:0] i_trap_pc;
    logic [31:0] i_trap_tval;
    logic        i_mret;
    logic        i_retire;
    logic [31:0] o_trap_vector;
    logic [31:0] o_mepc;
    logic        o_mie_global;

    int n_checks = 0;
    int n_errors = 0;

    csr_file dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_csr_en       (i_csr_en),
        .i_csr_op       (i_csr_op),
        .i_csr_addr     (i_csr_addr),
        .i_csr_wdata    (i_csr_wdata),
        .i_csr_src_zero (i_csr_src_zero),
        .o_csr_rdata    (o_csr_rdata),
        .o_csr_illegal  (o_csr_illegal),
        .i_trap_req     (i_trap_req),
        .i_trap_cause   (i_trap_cause),
        .i_trap_pc      (i_trap_pc),
        .i_trap_tval    (i_trap_tval),
        .i_mret         (i_mret),
        .i_retire       (i_retire),
        .o_trap_vector  (o_trap_vector),
        .o_mepc         (o_mepc),
        .o_mie_global   (o_mie_global)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_csr_en       = 1'b0;
        i_csr_op       = OP_NOP;
        i_csr_addr     = '0;
        i_csr_wdata    = '0;
        i_csr_src_zero = 1'b0;
        i_trap_req     = 1'b0;
        i_trap_cause   = '0;
        i_trap_pc      = '0;
        i_trap_tval    = '0;
        i_mret         = 1'b0;
        i_retire       = 1'b0;
    endtask

    // csrr-style read: RS with x0 source, no state effect
    task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        i_csr_en       = 1'b1;
        i_csr_op       = OP_RS;
        i_csr_addr     = addr;
        i_csr_wdata    = '0;
        i_csr_src_zero = 1'b1;
        #1;
        check(tag, o_csr_rdata, exp);
        check({tag, "_legal"}, 32'(o_csr_illegal), 32'd0);
        i_csr_en       = 1'b0;
        i_csr_src_zero = 1'b0;
    endtask

    task automatic csr_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        @(negedge i_clk);
        i_csr_en    = 1'b1;
        i_csr_op    = op;
        i_csr_addr  = addr;
        i_csr_wdata = wdata;
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
        @(negedge i_clk);
        i_trap_req   = 1'b1;
        i_trap_pc    = pc;
        i_trap_cause = cause;
        i_trap_tval  = tval;
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic mret();
        @(negedge i_clk);
        i_mret = 1'b1;
        @(posedge i_clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_tvec", o_trap_vector, 32'h0000_0000);
        check("rst_mepc", o_mepc, 32'h0);
        check("rst_mie_g", 32'(o_mie_global), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        csr_read("rst_mtvec", 12'h305, 32'h0000_0000);
        csr_read("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_read("rst_misa", 12'h301, 32'h4000_0100);

        // Enable MIE, take an exception, return
        csr_op(OP_RS, 12'h300, 32'h8);
        csr_read("mie_set", 12'h300, 32'h0000_1808);
        check("mie_g_set", 32'(o_mie_global), 32'd1);
        trap(32'h0000_0106, 32'h2, 32'hDEAD_BEEF);
        check("trap_mepc_o", o_mepc, 32'h0000_0104);
        csr_read("trap_mepc", 12'h341, 32'h0000_0104);
        csr_read("trap_mcause", 12'h342, 32'h2);
        csr_read("trap_mtval", 12'h343, 32'hDEAD_BEEF);
        csr_read("trap_mstatus", 12'h300, 32'h0000_1880);
        check("trap_mie_g", 32'(o_mie_global), 32'd0);
        mret();
        csr_read("mret_mstatus", 12'h300, 32'h0000_1888);
        check("mret_mie_g", 32'(o_mie_global), 32'd1);

        // mtvec modes and trap vector
        csr_op(OP_RW, 12'h305, 32'h0000_1001);
        csr_read("mtvec_vec", 12'h305, 32'h0000_1001);
        i_trap_cause = 32'h8000_0007;
        #1;
        check("tvec_irq7", o_trap_vector, 32'h0000_101C);
        i_trap_cause = 32'h0000_0003;
        #1;
        check("tvec_exc3", o_trap_vector, 32'h0000_1000);
        csr_op(OP_RW, 12'h305, 32'h0000_2003);
        csr_read("mtvec_mode3", 12'h305, 32'h0000_2000);
        i_trap_cause = 32'h8000_0007;
        #1;
        check("tvec_direct", o_trap_vector, 32'h0000_2000);
        i_trap_cause = '0;

        // WARL fields
        csr_op(OP_RW, 12'h341, 32'h0000_0203);
        csr_read("mepc_align", 12'h341, 32'h0000_0200);
        csr_op(OP_RW, 12'h304, 32'hFFFF_FFFF);
        csr_read("mie_mask", 12'h304, 32'h0000_0888);
        csr_op(OP_RC, 12'h304, 32'h0000_0008);
        csr_read("mie_rc", 12'h304, 32'h0000_0880);
        csr_op(OP_RW, 12'h301, 32'h0);
        csr_read("misa_ro", 12'h301, 32'h4000_0100);

        // Illegal and read-only accesses
        @(negedge i_clk);
        i_csr_en    = 1'b1;
        i_csr_op    = OP_RW;
        i_csr_addr  = 12'hF14;
        i_csr_wdata = 32'h5;
        #1;
        check("ill_rw_f14", 32'(o_csr_illegal), 32'd1);
        i_csr_op = OP_RS;
        #1;
        check("ill_rs_f14", 32'(o_csr_illegal), 32'd1);
        @(posedge i_clk);
        #1;
        idle();
        csr_read("hartid", 12'hF14, 32'h0);
        i_csr_en   = 1'b1;
        i_csr_op   = OP_RS;
        i_csr_addr = 12'h7C0;
        i_csr_src_zero = 1'b1;
        #1;
        check("ill_unmapped", 32'(o_csr_illegal), 32'd1);
        i_csr_en = 1'b0;
        #1;
        check("ill_gated_en", 32'(o_csr_illegal), 32'd0);
        idle();

        // mcycle carry from a written low half
        csr_op(OP_RW, 12'hB00, 32'hFFFF_FFFF);
        csr_read("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
        csr_read("mcycleh_pre", 12'hB80, 32'h0);
        @(posedge i_clk);
        #1;
        csr_read("mcycle_wrap", 12'hB00, 32'h0);
        csr_read("mcycleh_carry", 12'hB80, 32'h1);
        csr_read("cycleh_shadow", 12'hC80, 32'h1);

        // Trap wins over a same-cycle CSR write
        csr_op(OP_RW, 12'h340, 32'h11);
        csr_read("mscratch", 12'h340, 32'h11);
        @(negedge i_clk);
        i_csr_en     = 1'b1;
        i_csr_op     = OP_RW;
        i_csr_addr   = 12'h340;
        i_csr_wdata  = 32'h55;
        i_trap_req   = 1'b1;
        i_trap_pc    = 32'h0000_0200;
        i_trap_cause = 32'h8000_000B;
        i_trap_tval  = 32'h0;
        @(posedge i_clk);
        #1;
        idle();
        csr_read("trapwr_scratch", 12'h340, 32'h11);
        csr_read("trapwr_mcause", 12'h342, 32'h8000_000B);
        csr_read("trapwr_mepc", 12'h341, 32'h0000_0200);
        mret();
        check("mret2_mie_g", 32'(o_mie_global), 32'd1);

        // minstret: write beats retire, retire under trap is dropped
        @(negedge i_clk);
        i_csr_en    = 1'b1;
        i_csr_op    = OP_RW;
        i_csr_addr  = 12'hB02;
        i_csr_wdata = 32'd100;
        i_retire    = 1'b1;
        @(posedge i_clk);
        #1;
        idle();
        csr_read("minstret_wr", 12'hB02, 32'd100);
        @(negedge i_clk);
        i_retire = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        idle();
        csr_read("minstret_ret3", 12'hB02, 32'd103);
        @(negedge i_clk);
        i_retire   = 1'b1;
        i_trap_req = 1'b1;
        i_trap_pc  = 32'h0000_0300;
        @(posedge i_clk);
        #1;
        idle();
        csr_read("minstret_trap", 12'hC02, 32'd103);
        mret();

        // Asynchronous reset mid-cycle with a write in flight
        @(negedge i_clk);
        i_csr_en    = 1'b1;
        i_csr_op    = OP_RW;
        i_csr_addr  = 12'h340;
        i_csr_wdata = 32'h77;
        #2;
        i_rst = 1'b0;
        #1;
        check("arst_mepc", o_mepc, 32'h0);
        check("arst_mie_g", 32'(o_mie_global), 32'd0);
        check("arst_tvec", o_trap_vector, 32'h0);
        idle();
        csr_read("arst_mstatus", 12'h300, 32'h0000_1800);
        csr_read("arst_minstret", 12'hB02, 32'h0);
        csr_read("arst_mcause", 12'h342, 32'h0);
        csr_read("arst_mie", 12'h304, 32'h0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        csr_read("arst_scratch", 12'h340, 32'h0);
        csr_read("arst_mtvec", 12'h305, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR file and trap-state holder for the single-cycle RV32I core.
- Sits directly downstream of trap dispatch. It consumes trap request, cause, PC and tval, and latches them into mepc, mcause and mtval.
- Provides the trap vector and the mret return address to instruction fetch.
- Serves Zicsr read/modify/write accesses decoded by the CU.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (direct mode).
- MISA_VALUE, 32'h4000_0100, read-only misa value (RV32I).
- HART_ID, 0, read-only mhartid value.

Ports:
- i_clk  in  1  core clock, all state updates on its rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_csr_en  in  1  a CSR instruction is executing this cycle.
- i_csr_op  in  2  operation: 01 RW, 10 RS (set), 11 RC (clear); 00 is a no-op.
- i_csr_addr  in  12  CSR address.
- i_csr_wdata  in  32  operand value (rs1 value or zero-extended uimm).
- i_csr_src_zero  in  1  source field is x0 or uimm=0; suppresses the write for RS/RC.
- o_csr_rdata  out  32  combinational old value of the addressed CSR.
- o_csr_illegal  out  1  combinational illegal-access flag, fed to trap dispatch.
- i_trap_req  in  1  trap taken this cycle.
- i_trap_cause  in  32  mcause value: bit31 = interrupt, [30:0] = code.
- i_trap_pc  in  32  PC of the trapping instruction.
- i_trap_tval  in  32  mtval value.
- i_mret  in  1  mret executing this cycle.
- i_retire  in  1  instruction completes this cycle.
- o_trap_vector  out  32  fetch target on trap.
- o_mepc  out  32  mret return target.
- o_mie_global  out  1  mstatus.MIE.

Behaviour:
- Reset (i_rst low, asynchronous):
  - mstatus.MIE = 0 and MPIE = 0.
  - mtvec = MTVEC_RESET.
  - mepc, mcause, mtval, mscratch, mie, mcycle[63:0] and minstret[63:0] all = 0.
  - Outputs follow from these values: o_trap_vector = MTVEC_RESET, o_mepc = 0, o_mie_global = 0.
  - A reset asserted mid-operation discards any write in flight.
- Address map and access rules:
  - Read/write: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0xB00 mcycle, 0xB02 minstret, 0xB80 mcycleh, 0xB82 minstreth.
  - Read-only: 0x301 misa, 0x344 mip (reads 0), 0xF11–0xF13 (read 0), 0xF14 mhartid, 0xC00/0xC02/0xC80/0xC82 as shadows of mcycle/minstret.
- Write value by operation:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with i_csr_src_zero set perform no write and are legal on read-only CSRs.
- o_csr_illegal = i_csr_en & (unmapped address | (write attempted & addr[11:10]==2'b11)).
  - An illegal access performs no state change.
- WARL field rules:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
  - mtvec: MODE[1:0] values 2 or 3 are stored as 0.
  - mepc: bits[1:0] are forced to 0 on every write path.
  - mie: only bits 3, 7 and 11 are writable.
- Update priority per cycle: trap > mret > CSR write.
  - CSR write and mret are ignored in a cycle with i_trap_req.
- Trap entry:
  - mepc = {i_trap_pc[31:2], 2'b00}, mcause = i_trap_cause, mtval = i_trap_tval.
  - MPIE = MIE, then MIE = 0.
- mret: MIE = MPIE, MPIE = 1.
- o_trap_vector (combinational from current mtvec and i_trap_cause):
  - Direct mode, or any exception: {mtvec[31:2], 2'b00}.
  - Vectored mode with an interrupt: {mtvec[31:2], 2'b00} + (cause[30:0] << 2), 32-bit wrap.
- o_mepc = mepc register.
- mcycle: 64-bit counter, +1 every cycle.
  - A CSR write to a half replaces that half; the other half still advances with carry that cycle, and the written half does not increment.
  - Wraps from 2^64-1 to 0.
- minstret: +1 when i_retire & ~i_trap_req.
  - The same write-precedence rule as mcycle applies.
  - A CSR instruction that writes minstret and retires loads the written value without increment.
- Reads always return the pre-update value. There is no same-cycle bypass.

Test Plan:
- Reset, then read 0x305, 0x300 and 0x301 -> 0x0000_0000, 0x0000_1800 and 0x4000_0100; o_mie_global = 0.
- Set MIE with RS 0x300, wdata = 8. Trap with pc 0x104, cause 2, tval 0xDEAD_BEEF -> mepc = 0x104, mcause = 2, mtval = 0xDEAD_BEEF, mstatus reads 0x1880. Then mret -> mstatus reads 0x1888.
- RW 0x305 wdata 0x0000_1001, then drive interrupt cause 0x8000_0007 -> o_trap_vector = 0x101C. Exception cause 3 -> 0x1000. RW wdata 0x0000_2003 -> mtvec reads 0x2000.
- RW 0xF14 -> o_csr_illegal = 1, no state change. RS 0xF14 with src_zero -> legal, rdata = HART_ID. Read 0x7C0 -> illegal.
- RW mcycle 0xFFFF_FFFF, then read 0xB80 -> mcycleh = 1 one cycle after the carry. In the same cycle as a trap, RW mscratch 0x55 -> mscratch unchanged, trap state latched.
- Assert i_retire with i_trap_req -> minstret unchanged. Assert reset mid-stream -> all CSRs return to their reset values immediately, without waiting for a clock edge.
